// File: rtl/cb_cfg_loader.sv
// Word-serial connection-block config loader: shadow assembly, then atomic one-cycle commit to cfg.
// Optional even-parity check on each load word when CB_CFG_PARITY_EN is defined.
module cb_cfg_loader #(
   parameter int CFG_SIZE   = 256,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] wdata,
   input  logic                  wvalid,
`ifdef CB_CFG_PARITY_EN
   input  logic                  wpar,
`endif
   output logic                  wready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CFG_SIZE-1:0]   cfg
);
   localparam int NWORDS = (CFG_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CFG_SIZE-1:0] shadow_q, shadow_d;
   logic [CFG_SIZE-1:0] cfg_q, cfg_d;
   logic                accept;
   logic                sess_bad;

   // A word handshaken together with abort is dropped.
   assign accept = (state_q == S_LOAD) && wvalid && !abort;

`ifdef CB_CFG_PARITY_EN
   logic err_q, err_d;
   logic par_bad;

   assign par_bad  = ((^wdata) != wpar);
   assign sess_bad = err_q || par_bad;
   assign err      = err_q;

   always_comb begin
      err_d = err_q;
      if (state_q == S_IDLE && start && !abort) begin
         err_d = 1'b0;
      end else if (accept && par_bad) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign sess_bad = 1'b0;
   assign err      = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      cfg_d    = cfg_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d  = S_LOAD;
               cnt_d    = '0;
               shadow_d = '0;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d  = S_IDLE;
               cnt_d    = '0;
               shadow_d = '0;
            end else if (accept) begin
               // Bits beyond CFG_SIZE in the last word have no destination.
               for (int i = 0; i < CFG_SIZE; i++) begin
                  if (cnt_q == CW'(i / WORD_WIDTH)) begin
                     shadow_d[i] = wdata[i % WORD_WIDTH];
                  end
               end
               if (cnt_q == LAST_WORD) begin
                  cnt_d = '0;
                  if (sess_bad) begin
                     state_d  = S_IDLE;
                     shadow_d = '0;
                  end else begin
                     state_d = S_COMMIT;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_COMMIT: begin
            cfg_d   = shadow_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         cfg_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         cfg_q    <= cfg_d;
      end
   end

   assign wready = (state_q == S_LOAD);
   assign busy   = (state_q == S_LOAD) || (state_q == S_COMMIT);
   assign done   = (state_q == S_COMMIT);
   assign cfg    = cfg_q;

endmodule

// File: tb/tb_cb_cfg_loader.sv
// Directed bench for cb_cfg_loader: cycle table for a full load plus hand sequences for corner cases.
module tb_cb_cfg_loader;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0, start2 = 1'b0, abort = 1'b0, wvalid = 1'b0;
   logic [31:0]  wdata = '0;
   logic         wpar = 1'b0;
   logic         wready, busy, done, err;
   logic [255:0] cfg;
   logic         wready2, busy2, done2, err2;
   logic [39:0]  cfg2;

   int checks = 0, failures = 0;
   int acc_cnt = 0, done_cnt = 0, bad_acc = 0;

   cb_cfg_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .wdata(wdata), .wvalid(wvalid),
`ifdef CB_CFG_PARITY_EN
      .wpar(wpar),
`endif
      .wready(wready), .busy(busy), .done(done), .err(err), .cfg(cfg)
   );

   cb_cfg_loader #(.CFG_SIZE(40), .WORD_WIDTH(32)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .wdata(wdata), .wvalid(wvalid),
`ifdef CB_CFG_PARITY_EN
      .wpar(wpar),
`endif
      .wready(wready2), .busy(busy2), .done(done2), .err(err2), .cfg(cfg2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wvalid && wready) acc_cnt <= acc_cnt + 1;
      if (wvalid && wready && (wpar != ^wdata)) bad_acc <= bad_acc + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic        start;
      logic        wvalid;
      logic [31:0] wdata;
      logic        exp_wready;
      logic        exp_busy;
      logic        exp_done;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] pat(input logic [31:0] base);
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = base + 32'(k);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input bit bad);
      wdata  = d;
      wpar   = (^d) ^ bad;
      wvalid = 1'b1;
      for (int t = 0; t < 16; t++) begin
         if (wready) begin
            tick();
            wvalid = 1'b0;
            return;
         end
         tick();
      end
      wvalid = 1'b0;
      checks++;
      failures++;
      $display("FAIL send_timeout: wready stayed 0 for word %0h", d);
   endtask

   task automatic full_load(input logic [31:0] base, input bit toggle, input bit abort_commit,
                            input int bad_idx);
      int d0, a0, b0;
      bit ec;
      logic [255:0] prior;
      d0 = done_cnt; a0 = acc_cnt; b0 = bad_acc; prior = cfg;
`ifdef CB_CFG_PARITY_EN
      ec = (bad_idx < 0);
`else
      ec = 1'b1;
`endif
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         send_word(base + 32'(k), k == bad_idx);
         if (toggle && k < 7) pulse_start();
      end
      abort = abort_commit;
      chk("last_word_done", 256'(done), 256'(ec));
      chk("last_word_busy", 256'(busy), 256'(ec));
      chk("last_word_err", 256'(err), 256'(!ec));
      tick();
      abort = 1'b0;
      chk("post_commit_done", 256'(done), 256'(0));
      chk("post_commit_busy", 256'(busy), 256'(0));
      chk("done_count", 256'(done_cnt - d0), 256'(ec));
      chk("accepted_words", 256'(acc_cnt - a0), 256'(8));
      chk("bad_words_sent", 256'(bad_acc - b0), 256'(bad_idx >= 0));
      chk("cfg_after_load", cfg, ec ? pat(base) : prior);
   endtask

   initial begin
      logic [255:0] prior;
      int d0;

      vt[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
      for (int k = 1; k <= 8; k++) vt[k] = '{1'b0, 1'b1, 32'(k), 1'b1, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1};
      vt[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

      #12;
      chk("rst_cfg", cfg, 256'(0));
      chk("rst_cfg2", 256'(cfg2), 256'(0));
      chk("rst_wready", 256'(wready), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Full 8-word load, cycle by cycle
      for (int i = 0; i < 11; i++) begin
         start  = vt[i].start;
         wvalid = vt[i].wvalid;
         wdata  = vt[i].wdata;
         wpar   = ^vt[i].wdata;
         chk($sformatf("vec%0d_wready", i), 256'(wready), 256'(vt[i].exp_wready));
         chk($sformatf("vec%0d_busy", i), 256'(busy), 256'(vt[i].exp_busy));
         chk($sformatf("vec%0d_done", i), 256'(done), 256'(vt[i].exp_done));
         tick();
      end
      chk("cfg_lo_word", 256'(cfg[31:0]), 256'(1));
      chk("cfg_hi_word", 256'(cfg[255:224]), 256'(8));
      chk("cfg_full", cfg, pat(32'd1));
      chk("table_done_count", 256'(done_cnt), 256'(1));

      // Non-multiple config size: upper bits of the last word are dropped
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      wdata  = 32'hFFFF_FFFF;
      wpar   = ^wdata;
      wvalid = 1'b1;
      chk("cfg40_wready0", 256'(wready2), 256'(1));
      tick();
      chk("cfg40_wready1", 256'(wready2), 256'(1));
      tick();
      wvalid = 1'b0;
      chk("cfg40_done", 256'(done2), 256'(1));
      tick();
      chk("cfg40_done_once", 256'(done2), 256'(0));
      chk("cfg40_busy", 256'(busy2), 256'(0));
      chk("cfg40_err", 256'(err2), 256'(0));
      chk("cfg40_value", 256'(cfg2), 256'(40'hFF_FFFF_FFFF));

      // Abort after 3 words, with a word offered in the abort cycle
      prior = cfg;
      d0 = done_cnt;
      pulse_start();
      for (int k = 0; k < 3; k++) send_word(32'hA0 + 32'(k), 1'b0);
      abort  = 1'b1;
      wvalid = 1'b1;
      wdata  = 32'hDEAD;
      wpar   = ^wdata;
      chk("abort_busy_before", 256'(busy), 256'(1));
      tick();
      abort  = 1'b0;
      wvalid = 1'b0;
      chk("abort_busy_after", 256'(busy), 256'(0));
      chk("abort_wready_after", 256'(wready), 256'(0));
      tick();
      chk("abort_no_done", 256'(done_cnt - d0), 256'(0));
      chk("abort_cfg_kept", cfg, prior);

      // Abort during COMMIT is ignored
      full_load(32'h200, 1'b0, 1'b1, -1);

      // Asynchronous reset after 5 words, then a fresh load
      pulse_start();
      for (int k = 0; k < 5; k++) send_word(32'h50 + 32'(k), 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_cfg", cfg, 256'(0));
      chk("midreset_busy", 256'(busy), 256'(0));
      chk("midreset_wready", 256'(wready), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      full_load(32'h100, 1'b0, 1'b0, -1);

      // wvalid alternating with start pulses during LOAD
      full_load(32'h300, 1'b1, 1'b0, -1);

      // start together with abort in IDLE stays idle
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", 256'(busy), 256'(0));
      chk("start_abort_wready", 256'(wready), 256'(0));

      // Word 2 carries wrong parity
      full_load(32'h400, 1'b0, 1'b0, 2);
`ifdef CB_CFG_PARITY_EN
      chk("err_sticky", 256'(err), 256'(1));
      pulse_start();
      chk("err_cleared_by_start", 256'(err), 256'(0));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("err_session_aborted", 256'(busy), 256'(0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
